// File: rtl/mat_sched_pkg.sv
// Shared types and constants for the matrix add/sub scheduler.
package mat_sched_pkg;

  localparam int MAT_W = 32;   // 16 x 2-bit operand elements
  localparam int RES_W = 96;   // 16 x 6-bit result fields
  localparam int N_REQ = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

  // Operand bundle one requester presents; also the latched copy driving the datapath.
  typedef struct packed {
    logic [MAT_W-1:0] a;
    logic [MAT_W-1:0] b;
    logic             sign;
  } opnd_t;

endpackage

// File: rtl/mat_addsub_sched_arb.sv
// Two-way round-robin arbiter. Purely combinational; the parent holds the pointer.
module rr_arb2
  import mat_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,   // index of the most recently granted requester
  output logic [N_REQ-1:0] win     // one-hot winner, zero when nobody requests
);

  // Lone requester always wins; on contention the one not served last wins.
  always_comb begin
    win = '0;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = '0;
    endcase
  end

endmodule

// File: rtl/mat_addsub_sched.sv
// Shares one matrix add/sub datapath between two requesters: arbitrate,
// latch operands, clear the datapath, launch it, wait (bounded) for finish,
// capture the result and return a per-requester done pulse.
module mat_addsub_sched
  import mat_sched_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4    // 2**CNT_W must exceed TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      op,
  input  logic [MAT_W-1:0]      a0,
  input  logic [MAT_W-1:0]      b0,
  input  logic [MAT_W-1:0]      a1,
  input  logic [MAT_W-1:0]      b1,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  err,
  output logic [RES_W-1:0]      result,
  output logic                  busy,
  output logic                  dp_rst,
  output logic                  dp_add_en,
  output logic                  dp_sign,
  output logic [MAT_W-1:0]      dp_mat_A,
  output logic [MAT_W-1:0]      dp_mat_B,
  input  logic [RES_W-1:0]      dp_mat_out,
  input  logic                  dp_finish
);

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   win;
  logic               last;        // last granted requester index
  logic               owner;       // requester currently being served
  logic [CNT_W-1:0]   cnt;
  logic               err_q;
  logic               cnt_max;
  opnd_t              req_opnd [N_REQ];
  opnd_t              opnd;

  assign req_opnd[0] = '{a: a0, b: b0, sign: op[0]};
  assign req_opnd[1] = '{a: a1, b: b1, sign: op[1]};

  rr_arb2 u_arb (
    .req  (req),
    .last (last),
    .win  (win)
  );

  assign cnt_max = (cnt == CNT_W'(TIMEOUT - 1));

  // Next-state: one clear cycle and one launch cycle, then a bounded wait.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = CLR;
      CLR:     state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (dp_finish || cnt_max) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grant-time capture: winner's operands, owner, and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd  <= '0;
      owner <= 1'b0;
      last  <= 1'b1;           // pretend requester 1 went last so requester 0 is preferred
    end else if (state == IDLE && |win) begin
      opnd  <= req_opnd[win[1]];
      owner <= win[1];
      last  <= win[1];
    end
  end

  // Wait counter: cleared on launch, counts only while no finish is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       cnt <= '0;
    else if (state == LAUNCH)                         cnt <= '0;
    else if (state == WAIT && !dp_finish && !cnt_max) cnt <= cnt + 1'b1;
  end

  // Completion bookkeeping: finish captures the result, timeout only flags err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      err_q  <= 1'b0;
    end else if (state == WAIT) begin
      if (dp_finish) begin
        result <= dp_mat_out;
        err_q  <= 1'b0;
      end else if (cnt_max) begin
        err_q  <= 1'b1;
      end
    end
  end

  // The datapath parks in its finish state, so it is cleared before every op
  // and also held in reset for as long as the system reset is low.
  assign dp_rst    = ~rst_n | (state == CLR);
  assign dp_add_en = (state == LAUNCH);
  assign dp_sign   = opnd.sign;
  assign dp_mat_A  = opnd.a;
  assign dp_mat_B  = opnd.b;

  assign busy = (state != IDLE);
  assign gnt  = (state == CLR)  ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign done = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign err  = (state == RESP) & err_q;

endmodule

// File: tb/tb_mat_addsub_sched.sv
// Bench for mat_addsub_sched: stand-in datapath, timing-level reference model
// checked every cycle, directed scenarios with literal expectations, random phase.
module tb_mat_addsub_sched;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  op = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]  gnt, done;
  logic        err, busy, dp_rst, dp_add_en, dp_sign;
  logic [95:0] result;
  logic [31:0] dp_mat_A, dp_mat_B;
  logic [95:0] dp_mat_out = '0;
  logic        dp_finish = 1'b0;
  logic        dp_stall = 1'b0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  mat_addsub_sched #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .dp_rst(dp_rst), .dp_add_en(dp_add_en), .dp_sign(dp_sign),
    .dp_mat_A(dp_mat_A), .dp_mat_B(dp_mat_B),
    .dp_mat_out(dp_mat_out), .dp_finish(dp_finish)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  // Element-wise 2-bit add/sub into 3 bits, zero-padded into 6-bit fields.
  function automatic logic [95:0] calc(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [95:0] r;
    logic [2:0]  e;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (s) e = {1'b0, a[31-2*k -: 2]} - {1'b0, b[31-2*k -: 2]};
      else   e = {1'b0, a[31-2*k -: 2]} + {1'b0, b[31-2*k -: 2]};
      r[95-6*k -: 6] = {3'b000, e};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Stand-in datapath: one cycle of shifting after enable, then finish parks high until reset.
  logic        pend = 1'b0, pend_stall = 1'b0, ps = 1'b0;
  logic [31:0] pa = '0, pb = '0;
  always @(posedge clk) begin
    if (dp_rst) begin
      dp_finish <= 1'b0; dp_mat_out <= '0; pend <= 1'b0;
    end else if (dp_add_en) begin
      pend <= 1'b1; pend_stall <= dp_stall; pa <= dp_mat_A; pb <= dp_mat_B; ps <= dp_sign;
    end else if (pend) begin
      pend <= 1'b0;
      if (!pend_stall) begin
        dp_finish  <= 1'b1;
        dp_mat_out <= calc(pa, pb, ps);
      end
    end
  end

  // Reference model: tracks grant/launch/done cycle numbers and expected values.
  int          m_g = -100, m_done = -100;
  logic        m_own = 1'b0, m_last = 1'b1, m_to = 1'b0, m_S = 1'b0;
  logic [31:0] m_A = '0, m_B = '0;
  logic [95:0] m_res = '0;

  always @(negedge clk) begin
    logic [1:0] eg, ed;
    if (!rst_n) begin
      m_g = -100; m_done = -100; m_last = 1'b1; m_to = 1'b0;
      m_A = '0; m_B = '0; m_S = 1'b0; m_res = '0;
      chk("rst_gnt",  96'(gnt), 96'(0));
      chk("rst_done", 96'(done), 96'(0));
      chk("rst_err",  96'(err), 96'(0));
      chk("rst_busy", 96'(busy), 96'(0));
      chk("rst_dprst", 96'(dp_rst), 96'(1));
      chk("rst_adden", 96'(dp_add_en), 96'(0));
      chk("rst_result", result, 96'(0));
      chk("rst_opnd", {dp_mat_A, dp_mat_B, 31'(0), dp_sign}, 96'(0));
    end else begin
      if (cyc == m_g + 1) begin
        m_to   = dp_stall;
        m_done = m_to ? cyc + 1 + TO : cyc + 3;
      end
      if (cyc == m_done && !m_to) m_res = calc(m_A, m_B, m_S);
      eg = (cyc == m_g)    ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      ed = (cyc == m_done) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
      chk("gnt",    96'(gnt),  96'(eg));
      chk("done",   96'(done), 96'(ed));
      chk("err",    96'(err),  96'((cyc == m_done) && m_to));
      chk("busy",   96'(busy), 96'((cyc >= m_g) && (cyc <= m_done)));
      chk("dp_rst", 96'(dp_rst), 96'(cyc == m_g));
      chk("dp_add_en", 96'(dp_add_en), 96'(cyc == m_g + 1));
      chk("result", result, m_res);
      chk("dp_opnd", {dp_mat_A, dp_mat_B, 31'(0), dp_sign}, {m_A, m_B, 31'(0), m_S});
      if (cyc > m_done && req != 2'b00) begin
        m_own  = (req == 2'b11) ? ~m_last : req[1];
        m_last = m_own;
        m_g    = cyc + 1;
        m_done = cyc + 1000;
        m_A    = m_own ? a1 : a0;
        m_B    = m_own ? b1 : b0;
        m_S    = op[m_own];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) tick();
    if (busy) chk("idle_wait", 96'(busy), 96'(0));
  endtask

  // Raise req in an IDLE cycle n; report gnt/done cycles relative to n.
  task automatic run_op(input logic [1:0] r, output int gr, output int dr,
                        output logic [1:0] gv, output logic [1:0] dv,
                        output logic ev, output logic rs);
    int n;
    wait_idle();
    req = r; n = cyc; gr = -1; dr = -1; gv = '0; dv = '0; ev = 1'b0; rs = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt != 2'b00 && gr < 0) begin gr = cyc - n; gv = gnt; rs = dp_rst; req = req & ~gnt; end
      if (done != 2'b00) begin dr = cyc - n; dv = done; ev = err; break; end
    end
    req = 2'b00;
    if (dr < 0) chk("done_wait", 96'(0), 96'(1));
  endtask

  initial begin
    int gr, dr, ng, nd;
    logic [1:0] gv, dv;
    logic ev, rs;
    int gcyc[4];
    logic [1:0] gown[4], down[4];

    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_result", result, 96'(0));

    // single add, requester 0
    a0 = 32'h55555555; b0 = 32'h55555555; op = 2'b00;
    run_op(2'b01, gr, dr, gv, dv, ev, rs);
    chk("add_gnt_lat", 96'(gr), 96'(1));
    chk("add_gnt", 96'(gv), 96'(2'b01));
    chk("add_done_lat", 96'(dr), 96'(5));
    chk("add_done", 96'(dv), 96'(2'b01));
    chk("add_err", 96'(ev), 96'(0));
    chk("add_result", result, {16{6'd2}});

    // single subtract, requester 1
    a1 = 32'hFFFFFFFF; b1 = 32'h55555555; op = 2'b10;
    run_op(2'b10, gr, dr, gv, dv, ev, rs);
    chk("sub_gnt", 96'(gv), 96'(2'b10));
    chk("sub_dprst_clr", 96'(rs), 96'(1));
    chk("sub_done_lat", 96'(dr), 96'(5));
    chk("sub_done", 96'(dv), 96'(2'b10));
    chk("sub_result", result, {16{6'd2}});

    // contention: grants alternate, 6 cycles apart
    a0 = 32'h55555555; b0 = 32'h55555555; a1 = 32'hAAAAAAAA; b1 = 32'h55555555; op = 2'b00;
    wait_idle();
    req = 2'b11; ng = 0; nd = 0;
    for (int i = 0; i < 80 && nd < 4; i++) begin
      tick();
      if (gnt != 2'b00 && ng < 4) begin gcyc[ng] = cyc; gown[ng] = gnt; ng++; if (ng == 4) req = 2'b00; end
      if (done != 2'b00 && nd < 4) begin down[nd] = done; nd++; end
    end
    req = 2'b00;
    chk("cont_count", 96'(nd), 96'(4));
    for (int k = 0; k < 4; k++) begin
      chk("cont_gnt_owner", 96'(gown[k]), 96'((k % 2) ? 2'b10 : 2'b01));
      chk("cont_done_owner", 96'(down[k]), 96'((k % 2) ? 2'b10 : 2'b01));
      if (k > 0) chk("cont_spacing", 96'(gcyc[k] - gcyc[k-1]), 96'(6));
    end
    chk("cont_result", result, {16{6'd3}});

    // timeout: no finish, err after TO cycles in WAIT, result kept
    dp_stall = 1'b1;
    run_op(2'b01, gr, dr, gv, dv, ev, rs);
    dp_stall = 1'b0;
    chk("to_done_lat", 96'(dr), 96'(3 + TO));
    chk("to_err", 96'(ev), 96'(1));
    chk("to_result_kept", result, {16{6'd3}});
    a0 = 32'hFFFFFFFF; b0 = 32'hFFFFFFFF;
    run_op(2'b01, gr, dr, gv, dv, ev, rs);
    chk("after_to_lat", 96'(dr), 96'(5));
    chk("after_to_err", 96'(ev), 96'(0));
    chk("after_to_result", result, {16{6'd6}});

    // reset during WAIT
    wait_idle();
    req = 2'b11;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 96'(busy), 96'(0));
    chk("midrst_result", result, 96'(0));
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrst_nodone", 96'(done), 96'(0));
    end
    rst_n = 1'b1;
    req = 2'b00;
    run_op(2'b11, gr, dr, gv, dv, ev, rs);
    chk("midrst_first_gnt", 96'(gv), 96'(2'b01));

    // back-to-back same requester while finish is still parked high
    wait_idle();
    req = 2'b01; ng = 0;
    for (int i = 0; i < 40 && ng < 2; i++) begin
      tick();
      if (gnt != 2'b00) begin gcyc[ng] = cyc; ng++; end
    end
    req = 2'b00;
    chk("b2b_count", 96'(ng), 96'(2));
    chk("b2b_spacing", 96'(gcyc[1] - gcyc[0]), 96'(6));

    // random phase
    for (int i = 0; i < 2000; i++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (req[r]) begin
          if (gnt[r] && $urandom_range(0, 1) == 0) req[r] = 1'b0;
          else if ($urandom_range(0, 15) == 0) req[r] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) req[r] = 1'b1;
      end
      op = 2'($urandom);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      dp_stall = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      end
    end
    req = 2'b00; dp_stall = 1'b0;
    wait_idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
